// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle controller and its instruction classifier.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } ctrl_state_e;

  typedef enum logic [3:0] {
    CLS_NOP    = 4'd0,
    CLS_RTYPE  = 4'd1,
    CLS_IMM    = 4'd2,
    CLS_SHIFT  = 4'd3,
    CLS_LOAD   = 4'd4,
    CLS_STORE  = 4'd5,
    CLS_BRANCH = 4'd6,
    CLS_JMP    = 4'd7,
    CLS_JSB    = 4'd8,
    CLS_RET    = 4'd9,
    CLS_HALT   = 4'd10
  } instr_class_e;

  // Opcode prefixes, matched against the most significant bits of the instruction.
  localparam logic [1:0] PFX_RTYPE  = 2'b00;
  localparam logic [1:0] PFX_IMM    = 2'b01;
  localparam logic [2:0] PFX_SHIFT  = 3'b110;
  localparam logic [2:0] PFX_MEM    = 3'b100;
  localparam logic [2:0] PFX_BRANCH = 3'b101;
  localparam logic [3:0] PFX_JUMP   = 4'b1110;
  localparam logic [5:0] PFX_RET    = 6'b111100;

  localparam logic [1:0] MEM_LOAD  = 2'b00;
  localparam logic [1:0] MEM_STORE = 2'b01;

  localparam logic [1:0] BR_Z  = 2'b00;
  localparam logic [1:0] BR_NZ = 2'b01;
  localparam logic [1:0] BR_C  = 2'b10;
  localparam logic [1:0] BR_NC = 2'b11;

  localparam logic [1:0] PC_SRC_INC   = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP  = 2'b01;
  localparam logic [1:0] PC_SRC_STACK = 2'b10;
  localparam logic [1:0] PC_SRC_BR    = 2'b11;

  function automatic logic branch_taken(input logic [1:0] cond, input logic zero,
                                        input logic carry);
    case (cond)
      BR_Z:    branch_taken = zero;
      BR_NZ:   branch_taken = !zero;
      BR_C:    branch_taken = carry;
      default: branch_taken = !carry;
    endcase
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational classifier: instruction register -> class, load/store flags, branch condition.
module instr_class_decode
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 19
) (
  input  logic [INSTR_W-1:0] ir,
  output instr_class_e       cls,
  output logic               is_load,
  output logic               is_store,
  output logic [1:0]         br_cond
);

  localparam int T = INSTR_W - 1;

  logic [1:0] sub;

  assign sub     = ir[T-3 -: 2];
  assign br_cond = sub;

  always_comb begin
    cls = CLS_NOP;
    if (&ir) begin
      cls = CLS_HALT;
    end else if (ir[T -: 2] == PFX_RTYPE) begin
      cls = CLS_RTYPE;
    end else if (ir[T -: 2] == PFX_IMM) begin
      cls = CLS_IMM;
    end else if (ir[T -: 3] == PFX_SHIFT) begin
      cls = CLS_SHIFT;
    end else if (ir[T -: 3] == PFX_MEM) begin
      // Memory subcodes other than load/store fall through as NOP.
      if (sub == MEM_LOAD) begin
        cls = CLS_LOAD;
      end else if (sub == MEM_STORE) begin
        cls = CLS_STORE;
      end
    end else if (ir[T -: 3] == PFX_BRANCH) begin
      cls = CLS_BRANCH;
    end else if (ir[T -: 4] == PFX_JUMP) begin
      cls = ir[T-4] ? CLS_JSB : CLS_JMP;
    end else if (ir[T -: 6] == PFX_RET) begin
      cls = CLS_RET;
    end
  end

  assign is_load  = (cls == CLS_LOAD);
  assign is_store = (cls == CLS_STORE);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with a shared ALU and memory port.
// Define STACK_GUARD_EN to build the call-depth counter and sticky stack_err trap.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int INSTR_W     = 19,
  parameter int STACK_DEPTH = 8,
  parameter int ACODE_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               zero,
  input  logic               carry,
  input  logic               mem_ready,
  output logic [INSTR_W-1:0] ir_q,
  output logic               pc_write,
  output logic               ir_write,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic               update_z_c,
  output logic               alu_src,
  output logic               is_shift,
  output logic               mem_or_alu,
  output logic               reg2_read_source,
  output logic               mem_read,
  output logic               mem_write,
  output logic               stack_push,
  output logic               stack_pop,
  output logic [1:0]         scode,
  output logic [ACODE_W-1:0] acode,
  output logic               halted,
  output logic               stack_err,
  output ctrl_state_e        state_dbg
);

  ctrl_state_e  state_q;
  instr_class_e cls;
  logic         is_load;
  logic         is_store;
  logic [1:0]   br_cond;
  logic         stack_fault;

  instr_class_decode #(.INSTR_W(INSTR_W)) u_decode (
    .ir       (ir_q),
    .cls      (cls),
    .is_load  (is_load),
    .is_store (is_store),
    .br_cond  (br_cond)
  );

`ifdef STACK_GUARD_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic [SP_W-1:0] sp_q;
  logic            stack_err_q;

  assign stack_fault = ((cls == CLS_JSB) && (sp_q == SP_W'(STACK_DEPTH))) ||
                       ((cls == CLS_RET) && (sp_q == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q        <= '0;
      stack_err_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      if (stack_fault) begin
        stack_err_q <= 1'b1;
      end else if (cls == CLS_JSB) begin
        sp_q <= sp_q + SP_W'(1);
      end else if (cls == CLS_RET) begin
        sp_q <= sp_q - SP_W'(1);
      end
    end
  end

  assign stack_err = stack_err_q;
`else
  assign stack_fault = 1'b0;
  assign stack_err   = 1'b0;
`endif

  // Memory handshake: mem_read/mem_write stay high for every MEM cycle; the access
  // completes on the rising edge where mem_ready=1, which is the last MEM cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          ir_q    <= instruction;
          state_q <= ST_DECODE;
        end
        ST_DECODE: state_q <= (cls == CLS_HALT) ? ST_HALT : ST_EXEC;
        ST_EXEC: begin
          case (cls)
            CLS_RTYPE, CLS_IMM, CLS_SHIFT: state_q <= ST_WB;
            CLS_LOAD, CLS_STORE:           state_q <= ST_MEM;
            CLS_JSB, CLS_RET:              state_q <= stack_fault ? ST_HALT : ST_FETCH;
            default:                       state_q <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            state_q <= is_load ? ST_WB : ST_FETCH;
          end
        end
        ST_WB:   state_q <= ST_FETCH;
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Strobes are gated by rst_n so an asserted reset silences them without waiting for a clock.
  always_comb begin
    pc_write         = 1'b0;
    ir_write         = 1'b0;
    pc_src           = PC_SRC_INC;
    reg_write        = 1'b0;
    update_z_c       = 1'b0;
    alu_src          = 1'b0;
    is_shift         = 1'b0;
    mem_or_alu       = 1'b0;
    reg2_read_source = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    stack_push       = 1'b0;
    stack_pop        = 1'b0;
    halted           = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        ST_EXEC: begin
          case (cls)
            CLS_IMM:   alu_src = 1'b1;
            CLS_SHIFT: is_shift = 1'b1;
            CLS_LOAD, CLS_STORE: begin
              alu_src          = 1'b1;
              reg2_read_source = 1'b1;
            end
            CLS_BRANCH: begin
              if (branch_taken(br_cond, zero, carry)) begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_BR;
              end
            end
            CLS_JMP: begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_JUMP;
            end
            CLS_JSB: begin
              if (!stack_fault) begin
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JUMP;
                stack_push = 1'b1;
              end
            end
            CLS_RET: begin
              if (!stack_fault) begin
                pc_write  = 1'b1;
                pc_src    = PC_SRC_STACK;
                stack_pop = 1'b1;
              end
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_read  = is_load;
          mem_write = is_store;
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_or_alu = !is_load;
          update_z_c = !is_load;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign acode     = ir_q[INSTR_W-3 -: ACODE_W];
  assign scode     = ir_q[INSTR_W-4 -: 2];
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control vectors checked against hand-computed values.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [18:0] instruction;
  logic        zero;
  logic        carry;
  logic        mem_ready;
  logic [18:0] ir_q;
  logic        pc_write, ir_write, reg_write, update_z_c, alu_src, is_shift;
  logic        mem_or_alu, reg2_read_source, mem_read, mem_write;
  logic        stack_push, stack_pop, halted, stack_err;
  logic [1:0]  pc_src;
  logic [1:0]  scode;
  logic [2:0]  acode;
  ctrl_state_e state_dbg;
  logic [14:0] ctl;

  int checks = 0;
  int errors = 0;

  localparam logic [14:0] C_PCW  = 15'h4000;
  localparam logic [14:0] C_IRW  = 15'h2000;
  localparam logic [14:0] C_JMP  = 15'h0800;
  localparam logic [14:0] C_STK  = 15'h1000;
  localparam logic [14:0] C_BR   = 15'h1800;
  localparam logic [14:0] C_RW   = 15'h0400;
  localparam logic [14:0] C_UZC  = 15'h0200;
  localparam logic [14:0] C_ASRC = 15'h0100;
  localparam logic [14:0] C_SHF  = 15'h0080;
  localparam logic [14:0] C_MOA  = 15'h0040;
  localparam logic [14:0] C_R2S  = 15'h0020;
  localparam logic [14:0] C_MRD  = 15'h0010;
  localparam logic [14:0] C_MWR  = 15'h0008;
  localparam logic [14:0] C_PSH  = 15'h0004;
  localparam logic [14:0] C_POP  = 15'h0002;
  localparam logic [14:0] C_HLT  = 15'h0001;
  localparam logic [14:0] V_FETCH = C_PCW | C_IRW;
  localparam logic [14:0] V_ALUWB = C_RW | C_UZC | C_MOA;

  localparam logic [18:0] I_ADD  = {2'b00, 3'b101, 14'h0123};
  localparam logic [18:0] I_IMM  = {2'b01, 3'b011, 14'h0042};
  localparam logic [18:0] I_SHF  = {3'b110, 2'b10, 14'h0007};
  localparam logic [18:0] I_LD   = {3'b100, 2'b00, 14'h0010};
  localparam logic [18:0] I_ST   = {3'b100, 2'b01, 14'h0011};
  localparam logic [18:0] I_MNOP = {3'b100, 2'b10, 14'h0000};
  localparam logic [18:0] I_BZ   = {3'b101, 2'b00, 14'h0005};
  localparam logic [18:0] I_BC   = {3'b101, 2'b10, 14'h0006};
  localparam logic [18:0] I_BNC  = {3'b101, 2'b11, 14'h0006};
  localparam logic [18:0] I_JMP  = {4'b1110, 1'b0, 14'h0020};
  localparam logic [18:0] I_JSB  = {4'b1110, 1'b1, 14'h0030};
  localparam logic [18:0] I_RET  = {6'b111100, 13'h0000};
  localparam logic [18:0] I_NOP  = {6'b111110, 13'h0000};
  localparam logic [18:0] I_HALT = 19'h7FFFF;

  assign ctl = {pc_write, ir_write, pc_src, reg_write, update_z_c, alu_src, is_shift,
                mem_or_alu, reg2_read_source, mem_read, mem_write, stack_push, stack_pop, halted};

  multicycle_controller #(.INSTR_W(19), .STACK_DEPTH(2), .ACODE_W(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instruction      (instruction),
    .zero             (zero),
    .carry            (carry),
    .mem_ready        (mem_ready),
    .ir_q             (ir_q),
    .pc_write         (pc_write),
    .ir_write         (ir_write),
    .pc_src           (pc_src),
    .reg_write        (reg_write),
    .update_z_c       (update_z_c),
    .alu_src          (alu_src),
    .is_shift         (is_shift),
    .mem_or_alu       (mem_or_alu),
    .reg2_read_source (reg2_read_source),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .stack_push       (stack_push),
    .stack_pop        (stack_pop),
    .scode            (scode),
    .acode            (acode),
    .halted           (halted),
    .stack_err        (stack_err),
    .state_dbg        (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the control vector of the current cycle, then advance to the next cycle.
  task automatic cyc(input string tag, input logic [14:0] exp);
    #1;
    check(tag, 32'(ctl), 32'(exp));
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    instruction = '0;
    zero        = 1'b0;
    carry       = 1'b0;
    mem_ready   = 1'b1;
    #2;
    check("reset_ctl", 32'(ctl), 32'h0);
    check("reset_ir", 32'(ir_q), 32'h0);
    check("reset_state", 32'(state_dbg), 32'(ST_FETCH));
    check("reset_err", 32'(stack_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type add: writeback in cycle 4, next fetch in cycle 5
    instruction = I_ADD;
    cyc("add_fetch", V_FETCH);
    check("add_acode", 32'(acode), 32'h5);
    cyc("add_decode", 15'h0);
    cyc("add_exec", 15'h0);
    cyc("add_wb", V_ALUWB);
    check("add_ir", 32'(ir_q), 32'(I_ADD));

    instruction = I_IMM;
    cyc("imm_fetch", V_FETCH);
    check("imm_acode", 32'(acode), 32'h3);
    cyc("imm_decode", 15'h0);
    cyc("imm_exec", C_ASRC);
    cyc("imm_wb", V_ALUWB);

    instruction = I_SHF;
    cyc("shf_fetch", V_FETCH);
    check("shf_scode", 32'(scode), 32'h2);
    cyc("shf_decode", 15'h0);
    cyc("shf_exec", C_SHF);
    cyc("shf_wb", V_ALUWB);

    // Load with three wait cycles: 8 cycles total
    instruction = I_LD;
    mem_ready   = 1'b0;
    cyc("ld_fetch", V_FETCH);
    cyc("ld_decode", 15'h0);
    cyc("ld_exec", C_ASRC | C_R2S);
    cyc("ld_mem1", C_MRD);
    cyc("ld_mem2", C_MRD);
    cyc("ld_mem3", C_MRD);
    mem_ready = 1'b1;
    cyc("ld_mem4", C_MRD);
    cyc("ld_wb", C_RW);

    instruction = I_ST;
    cyc("st_fetch", V_FETCH);
    cyc("st_decode", 15'h0);
    cyc("st_exec", C_ASRC | C_R2S);
    cyc("st_mem", C_MWR);

    instruction = I_MNOP;
    cyc("mnop_fetch", V_FETCH);
    cyc("mnop_decode", 15'h0);
    cyc("mnop_exec", 15'h0);

    instruction = I_BZ;
    zero        = 1'b1;
    cyc("bz_t_fetch", V_FETCH);
    cyc("bz_t_decode", 15'h0);
    cyc("bz_t_exec", C_PCW | C_BR);
    zero = 1'b0;
    cyc("bz_n_fetch", V_FETCH);
    cyc("bz_n_decode", 15'h0);
    cyc("bz_n_exec", 15'h0);

    instruction = I_BNC;
    cyc("bnc_fetch", V_FETCH);
    cyc("bnc_decode", 15'h0);
    cyc("bnc_exec", C_PCW | C_BR);
    instruction = I_BC;
    cyc("bc_n_fetch", V_FETCH);
    cyc("bc_n_decode", 15'h0);
    cyc("bc_n_exec", 15'h0);
    carry = 1'b1;
    cyc("bc_t_fetch", V_FETCH);
    cyc("bc_t_decode", 15'h0);
    cyc("bc_t_exec", C_PCW | C_BR);
    carry = 1'b0;

    instruction = I_JMP;
    cyc("jmp_fetch", V_FETCH);
    cyc("jmp_decode", 15'h0);
    cyc("jmp_exec", C_PCW | C_JMP);

    instruction = I_NOP;
    cyc("nop_fetch", V_FETCH);
    cyc("nop_decode", 15'h0);
    cyc("nop_exec", 15'h0);

`ifdef STACK_GUARD_EN
    instruction = I_JSB;
    cyc("jsb1_fetch", V_FETCH);
    cyc("jsb1_decode", 15'h0);
    cyc("jsb1_exec", C_PCW | C_JMP | C_PSH);
    cyc("jsb2_fetch", V_FETCH);
    cyc("jsb2_decode", 15'h0);
    cyc("jsb2_exec", C_PCW | C_JMP | C_PSH);
    check("jsb2_err", 32'(stack_err), 32'h0);
    cyc("jsb3_fetch", V_FETCH);
    cyc("jsb3_decode", 15'h0);
    cyc("jsb3_exec", 15'h0);
    check("ovf_err", 32'(stack_err), 32'h1);
    cyc("ovf_halt1", C_HLT);
    cyc("ovf_halt2", C_HLT);
    reset_dut();
    check("ovf_err_clr", 32'(stack_err), 32'h0);
    instruction = I_RET;
    cyc("unf_fetch", V_FETCH);
    cyc("unf_decode", 15'h0);
    cyc("unf_exec", 15'h0);
    check("unf_err", 32'(stack_err), 32'h1);
    cyc("unf_halt", C_HLT);
    reset_dut();
`else
    instruction = I_JSB;
    for (int i = 0; i < 3; i++) begin
      cyc("jsb_fetch", V_FETCH);
      cyc("jsb_decode", 15'h0);
      cyc("jsb_exec", C_PCW | C_JMP | C_PSH);
    end
    instruction = I_RET;
    cyc("ret_fetch", V_FETCH);
    cyc("ret_decode", 15'h0);
    cyc("ret_exec", C_PCW | C_STK | C_POP);
    check("ret_err", 32'(stack_err), 32'h0);
`endif

    // Reset during the second wait cycle of a store
    instruction = I_ST;
    mem_ready   = 1'b0;
    cyc("rst_st_fetch", V_FETCH);
    cyc("rst_st_decode", 15'h0);
    cyc("rst_st_exec", C_ASRC | C_R2S);
    cyc("rst_st_mem1", C_MWR);
    #1;
    check("rst_st_mem2", 32'(ctl), 32'(C_MWR));
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_st_mwr", 32'(mem_write), 32'h0);
    check("rst_st_ctl", 32'(ctl), 32'h0);
    check("rst_st_state", 32'(state_dbg), 32'(ST_FETCH));
    check("rst_st_ir", 32'(ir_q), 32'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    mem_ready   = 1'b1;
    instruction = I_ADD;
    cyc("resume_fetch", V_FETCH);
    cyc("resume_decode", 15'h0);
    cyc("resume_exec", 15'h0);
    cyc("resume_wb", V_ALUWB);

    instruction = I_HALT;
    cyc("halt_fetch", V_FETCH);
    cyc("halt_decode", 15'h0);
    instruction = I_ADD;
    cyc("halt_1", C_HLT);
    cyc("halt_2", C_HLT);
    cyc("halt_3", C_HLT);
    check("halt_ir", 32'(ir_q), 32'(I_HALT));
    check("halt_state", 32'(state_dbg), 32'(ST_HALT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
